// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: per-FU result FIFOs arbitrated round-robin onto the single register-file write port
// Optional WB_BYPASS_EN lets an empty channel compete straight from its inputs for 1-cycle latency.
module fu_wb_arbiter #(
   parameter int NUM_FU = 5,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_FU-1:0]         fu_valid,
   input  logic [NUM_FU*ADDR_W-1:0]  fu_rd,
   input  logic [NUM_FU*DATA_W-1:0]  fu_data,
   output logic [NUM_FU-1:0]         fu_ready,
   output logic                      wb_we,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic [DATA_W-1:0]         wb_data,
   output logic [$clog2(NUM_FU)-1:0] wb_src,
   output logic                      idle
);
   localparam int SRC_W = $clog2(NUM_FU);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [NUM_FU-1:0] empty, full, req, push, pop, take;
   logic [ADDR_W-1:0] in_rd [NUM_FU];
   logic [ADDR_W-1:0] head_rd [NUM_FU];
   logic [DATA_W-1:0] in_data [NUM_FU];
   logic [DATA_W-1:0] head_data [NUM_FU];
   logic [SRC_W-1:0]  rr, gnt_idx;
   logic              gnt;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_data;

   assign fu_ready = ~full;
   assign idle     = &empty & ~wb_we;
   assign pop      = take & ~empty;

`ifdef WB_BYPASS_EN
   assign req      = ~empty | fu_valid;
   assign push     = fu_valid & fu_ready & ~(take & empty);
   assign sel_rd   = empty[gnt_idx] ? in_rd[gnt_idx] : head_rd[gnt_idx];
   assign sel_data = empty[gnt_idx] ? in_data[gnt_idx] : head_data[gnt_idx];
`else
   assign req      = ~empty;
   assign push     = fu_valid & fu_ready;
   assign sel_rd   = head_rd[gnt_idx];
   assign sel_data = head_data[gnt_idx];
`endif

   for (genvar i = 0; i < NUM_FU; i++) begin : ch
      logic [ADDR_W-1:0] rd_q [DEPTH];
      logic [DATA_W-1:0] data_q [DEPTH];
      logic [PTR_W-1:0]  wp, rp;
      logic [CNT_W-1:0]  cnt;
      assign in_rd[i]     = fu_rd[i*ADDR_W +: ADDR_W];
      assign in_data[i]   = fu_data[i*DATA_W +: DATA_W];
      assign take[i]      = gnt && gnt_idx == SRC_W'(i);
      assign empty[i]     = cnt == '0;
      assign full[i]      = cnt == CNT_W'(DEPTH);
      assign head_rd[i]   = rd_q[rp];
      assign head_data[i] = data_q[rp];
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
         end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
         end else begin
            if (push[i]) wp <= wp + 1'b1;
            if (pop[i]) rp <= rp + 1'b1;
            cnt <= cnt + CNT_W'(push[i]) - CNT_W'(pop[i]);
         end
      end
      always_ff @(posedge clk) begin
         if (push[i]) begin
            rd_q[wp]   <= in_rd[i];
            data_q[wp] <= in_data[i];
         end
      end
   end

   // First requester at or after rr, wrapping modulo NUM_FU
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         if (!gnt && req[(int'(rr) + k) % NUM_FU]) begin
            gnt     = 1'b1;
            gnt_idx = SRC_W'((int'(rr) + k) % NUM_FU);
         end
      end
   end

   // rd==0 results still take the slot and move the pointer, but never assert the write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr      <= '0;
         wb_we   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
         wb_src  <= '0;
      end else if (flush) begin
         rr    <= '0;
         wb_we <= 1'b0;
      end else begin
         wb_we <= gnt && sel_rd != '0;
         if (gnt) begin
            rr      <= (gnt_idx == SRC_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
            wb_addr <= sel_rd;
            wb_data <= sel_data;
            wb_src  <= gnt_idx;
         end
      end
   end
endmodule
